// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the single-cycle CPU.
//
// Answers the MemRead/MemWrite strobes from the main control decoder using a
// word-addressed RAM. The access latency is a build-time parameter. The core is
// held through `stall` until the access completes.
//
// Parameters
//   ADDR_WIDTH  word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words
//   LATENCY     wait cycles inserted before commit, 0..15
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   MemRead   load request
//   MemWrite  store request
//   addr      byte address from the ALU; bits above ADDR_WIDTH+1 are ignored (wrap)
//   wdata     store data from the register-file rt port
//   rdata     registered load data, valid while done=1, held until the next commit
//   done      one-cycle access-complete strobe per accepted request
//   err       request rejected (misaligned or read+write), valid while done=1
//   stall     freeze PC and pipeline registers while 1

module dmem_resp #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall
);

    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LatCnt = LATENCY[3:0];

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;

    // Request fields captured in IDLE; later changes on the inputs are ignored.
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              align_q, align_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;

    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0]             ram_q [Depth];

    logic                    req;
    logic                    commit;
    logic                    ram_we;

    // Fields of the access being committed: live inputs when committing straight
    // out of IDLE (LATENCY=0), captured copies otherwise.
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [1:0]              acc_align;
    logic [31:0]             acc_wdata;
    logic                    acc_rd;
    logic                    acc_wr;
    logic                    acc_err;

    // Upper address bits only matter for wrap-around, i.e. they are dropped.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    assign req = MemRead | MemWrite;

    always_comb begin
        if (state_q == StIdle) begin
            acc_idx   = addr[ADDR_WIDTH+1:2];
            acc_align = addr[1:0];
            acc_wdata = wdata;
            acc_rd    = MemRead;
            acc_wr    = MemWrite;
        end else begin
            acc_idx   = idx_q;
            acc_align = align_q;
            acc_wdata = wdata_q;
            acc_rd    = rd_q;
            acc_wr    = wr_q;
        end
        acc_err = (acc_align != 2'b00) | (acc_rd & acc_wr);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        align_d = align_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d   = addr[ADDR_WIDTH+1:2];
                    align_d = addr[1:0];
                    wdata_d = wdata;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    cnt_d   = LatCnt;
                    if (LatCnt == 4'd0) begin
                        commit  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                // <= rather than == so a corrupted zero count cannot wedge the FSM.
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Strobes seen here belong to the retiring instruction.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (commit) begin
            err_d = acc_err;
            if (acc_rd && !acc_err) begin
                rdata_d = ram_q[acc_idx];
            end else begin
                rdata_d = 32'd0;
            end
        end
    end

    // rst_n gate keeps a LATENCY=0 request from writing while reset is held.
    assign ram_we = commit & acc_wr & ~acc_err & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            align_q <= 2'b00;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            align_q <= align_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[acc_idx] <= acc_wdata;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;
    assign done  = (state_q == StDone);
    assign stall = ((state_q == StIdle) & req) | (state_q == StWait);

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the single-cycle CPU. It answers the MemRead/MemWrite strobes raised by the main control decoder, using a word-addressed RAM with a programmable access latency. It holds the core through a stall signal until the access completes. It sits between the ALU result/register-file read port and the write-back mux (MemtoReg path).

## Interface
- ADDR_WIDTH, 8: word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: wait cycles inserted before commit; legal range 0..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- MemRead  in  1  load request from the control decoder.
- MemWrite  in  1  store request from the control decoder.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (register-file rt port).
- rdata  out  32  load data, registered; valid while done=1.
- done  out  1  access-complete strobe; one cycle per accepted request.
- err  out  1  request rejected; valid while done=1.
- stall  out  1  freeze PC and pipeline registers while 1.

## Operation
- FSM states: IDLE, WAIT, DONE. Latency counter: 4 bits.
- IDLE:
  - If req = MemRead|MemWrite is 1, capture addr, wdata, MemRead and MemWrite.
  - Load cnt=LATENCY.
  - Go to WAIT if LATENCY>0, otherwise go to DONE.
- WAIT: cnt decrements each cycle. On the edge where cnt==1, commit the access and go to DONE.
- DONE: done=1. Return to IDLE unconditionally. MemRead/MemWrite are ignored in DONE because they belong to the instruction being retired.
- Commit of a read: rdata <= ram[addr[ADDR_WIDTH+1:2]].
- Commit of a write: ram[addr[ADDR_WIDTH+1:2]] <= wdata, and rdata <= 0.
- Address wrap: address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the RAM size.
- Error request: addr[1:0]!=0, or MemRead and MemWrite both 1.
  - No RAM access; rdata <= 0.
  - err=1 together with done; the same latency still applies.
- stall = (state==IDLE & req) | (state==WAIT). stall is 0 in DONE, so the core advances on the DONE edge.
- RAM contents are not cleared by reset.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, cnt=0.
  - rdata=0, done=0, err=0.
  - stall follows its equation, so it is 0 unless a request is present in IDLE after release.
- Request sampled in cycle 0 (IDLE): done=1 in cycle LATENCY+1, and the next instruction is presented in cycle LATENCY+2. With LATENCY=0, done is in cycle 1.
- Total stall cycles per memory instruction: LATENCY+1.
- Back-to-back memory instructions: the new request is first seen in IDLE in the cycle after DONE. There are no idle gaps beyond that.
- Request fields are captured only in IDLE. Changes on addr, wdata, MemRead or MemWrite during WAIT/DONE have no effect.
- Reset asserted mid-WAIT: the access is abandoned, and a pending write is never committed. done is not produced.
- Non-memory instructions (req=0 in IDLE): stall=0, done=0, FSM stays in IDLE.
- rdata and err hold their values after DONE until the next commit.

## Test plan
- Reset: rst_n=0 mid-sim, with MemRead=0 and MemWrite=0 -> rdata=0, done=0, err=0, stall=0 immediately, with no clock edge needed.
- Write then read, LATENCY=2:
  - MemWrite with addr=0x10, wdata=0xDEADBEEF -> stall=1 for cycles 0-2 and done in cycle 3.
  - Then MemRead with addr=0x10 -> rdata=0xDEADBEEF and done=1 exactly 3 cycles after the request.
- Wrap, ADDR_WIDTH=8: write 0x12345678 to addr=0x400, then read addr=0x000 -> rdata=0x12345678.
- Misaligned: MemRead with addr=0x13 -> err=1 and rdata=0 with done. Then read 0x10 -> its prior contents are unchanged.
- Conflict: MemRead=MemWrite=1 with addr=0x20, wdata=0xFFFFFFFF -> err=1. A subsequent read of 0x20 returns its old value.
- Reset mid-operation: MemWrite 0xCAFEF00D to addr=0x30; pulse rst_n=0 in the WAIT cycle -> done never asserts, and a later read of 0x30 returns the pre-write value. Repeat with LATENCY=0 -> done in cycle 1, stall=1 only in cycle 0.
